// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: MDOp codes, FSM state encoding and op classifiers.
// Codes 9-12 (MADD family) launch only when MD_MADD_EN is defined.
package md_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;
    localparam logic [3:0] MD_MADD  = 4'd9;
    localparam logic [3:0] MD_MADDU = 4'd10;
    localparam logic [3:0] MD_MSUB  = 4'd11;
    localparam logic [3:0] MD_MSUBU = 4'd12;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Ops that use the multiplier timing.
    function automatic logic is_mult_op(input logic [3:0] op);
        logic r;
        r = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MD_MADD_EN
        r = r || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
        return r;
    endfunction

    // Ops that occupy the unit for several cycles and write HI/LO on completion.
    function automatic logic is_long_op(input logic [3:0] op);
        return is_mult_op(op) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// EX-stage handshake bundle between the pipeline and the multiply/divide unit.
// master = EX/pipeline side, slave = md_unit.
interface md_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       MDOp;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic [WIDTH-1:0] MDOut;

    modport master (
        output start, MDOp, A, B,
        input  busy, HI, LO, MDOut
    );

    modport slave (
        input  start, MDOp, A, B,
        output busy, HI, LO, MDOut
    );
endinterface

// File: rtl/md_core.sv
// Combinational {hi,lo} result for multiply/divide (and MADD family under MD_MADD_EN).
// Latency 0; no flow control -- the caller decides when to capture the result.
// Divide-by-zero and signed-overflow cases are resolved here so they can be tested in isolation.
module md_core
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    localparam int W2 = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [W2-1:0]    prod_s;
    logic [W2-1:0]    prod_u;
    logic             a_neg;
    logic             b_neg;
    logic             div_zero;
    logic             div_ovf;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] div_u;
    logic [WIDTH-1:0] div_s;
    logic [WIDTH-1:0] uq;
    logic [WIDTH-1:0] ur;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] mr;

    // Sign-extending to 2*WIDTH makes the truncated unsigned product equal the signed product.
    assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    assign a_neg    = a[WIDTH-1];
    assign b_neg    = b[WIDTH-1];
    assign div_zero = (b == '0);
    assign div_ovf  = (a == MOST_NEG) && (b == '1);
    assign abs_a    = a_neg ? (~a + ONE) : a;
    assign abs_b    = b_neg ? (~b + ONE) : b;

    // Divisors are forced non-zero so the dividers never see x/0; the result is overridden anyway.
    assign div_u = div_zero ? ONE : b;
    assign div_s = div_zero ? ONE : abs_b;
    assign uq    = a / div_u;
    assign ur    = a % div_u;
    assign mq    = abs_a / div_s;
    assign mr    = abs_a % div_s;

    always_comb begin
        res_hi = hi;
        res_lo = lo;
        case (op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV: begin
                if (div_zero) begin
                    res_lo = '1;
                    res_hi = a;
                end else if (div_ovf) begin
                    res_lo = MOST_NEG;
                    res_hi = '0;
                end else begin
                    res_lo = (a_neg ^ b_neg) ? (~mq + ONE) : mq;
                    res_hi = a_neg ? (~mr + ONE) : mr;
                end
            end
            MD_DIVU: begin
                if (div_zero) begin
                    res_lo = '1;
                    res_hi = a;
                end else begin
                    res_lo = uq;
                    res_hi = ur;
                end
            end
`ifdef MD_MADD_EN
            MD_MADD:  {res_hi, res_lo} = {hi, lo} + prod_s;
            MD_MADDU: {res_hi, res_lo} = {hi, lo} + prod_u;
            MD_MSUB:  {res_hi, res_lo} = {hi, lo} - prod_s;
            MD_MSUBU: {res_hi, res_lo} = {hi, lo} - prod_u;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle MULT/DIV unit owning HI/LO; MADD/MSUB family enabled by MD_MADD_EN.
// Latency: busy for MULT_CYCLES/DIV_CYCLES after launch; HI/LO update the cycle busy falls.
// No backpressure: start while busy is ignored (hazard unit stalls on start|busy).
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   md
);
    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] sh_hi_q;
    logic [WIDTH-1:0] sh_lo_q;
    logic [WIDTH-1:0] core_hi;
    logic [WIDTH-1:0] core_lo;
    logic             idle_start;
    logic             launch;
    logic             done;

    assign idle_start = (state_q == IDLE) && md.start;
    assign launch     = idle_start && is_long_op(md.MDOp);
    assign done       = (state_q == RUN) && (cnt_q == '0);

    md_core #(.WIDTH(WIDTH)) u_core (
        .op     (md.MDOp),
        .a      (md.A),
        .b      (md.B),
        .hi     (hi_q),
        .lo     (lo_q),
        .res_hi (core_hi),
        .res_lo (core_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (launch) state_d = RUN;
            RUN:     if (done)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        md.busy  = (state_q == RUN);
        md.HI    = hi_q;
        md.LO    = lo_q;
        md.MDOut = '0;
        if (md.MDOp == MD_MFHI) begin
            md.MDOut = hi_q;
        end else if (md.MDOp == MD_MFLO) begin
            md.MDOut = lo_q;
        end
    end

    // Result is captured at launch so operands may change while the unit counts down.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sh_hi_q <= '0;
            sh_lo_q <= '0;
        end else begin
            if (launch) begin
                cnt_q   <= is_mult_op(md.MDOp) ? MULT_LD : DIV_LD;
                sh_hi_q <= core_hi;
                sh_lo_q <= core_lo;
            end else if ((state_q == RUN) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end

            if (done) begin
                hi_q <= sh_hi_q;
                lo_q <= sh_lo_q;
            end else if (idle_start) begin
                if (md.MDOp == MD_MTHI) hi_q <= md.A;
                if (md.MDOp == MD_MTLO) lo_q <= md.A;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit with hand-computed HI/LO/busy expectations.
module tb_md_unit;
    import md_pkg::*;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;
    int   nb;

    md_unit_if #(.WIDTH(32)) mdi ();

    md_unit #(
        .WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mdi.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        mdi.MDOp  = op;
        mdi.A     = a;
        mdi.B     = b;
        mdi.start = 1'b1;
        step();
        mdi.start = 1'b0;
        mdi.MDOp  = MD_NONE;
        mdi.A     = 32'hA5A5_5A5A;
        mdi.B     = 32'h5A5A_A5A5;
    endtask

    // Counts sampled cycles with busy high; bounded so a stuck busy still reaches the summary.
    task automatic wait_idle(output int n);
        n = 0;
        while (mdi.busy === 1'b1 && n < 64) begin
            n++;
            step();
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int cycles,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        launch(op, a, b);
        wait_idle(n);
        check({tag, "_busy_cycles"}, n, cycles);
        check({tag, "_hi"}, mdi.HI, exp_hi);
        check({tag, "_lo"}, mdi.LO, exp_lo);
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        mdi.start = 1'b0;
        mdi.MDOp  = MD_NONE;
        mdi.A     = '0;
        mdi.B     = '0;
        step();
        step();
        reset = 1'b0;
        step();

        check("rst_busy", {31'd0, mdi.busy}, 32'd0);
        check("rst_hi", mdi.HI, 32'd0);
        check("rst_lo", mdi.LO, 32'd0);
        check("none_mdout", mdi.MDOut, 32'd0);

        run_op("mult", MD_MULT, 32'hFFFF_FFFD, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        mdi.MDOp = MD_MFHI;
        #1;
        check("mfhi_mdout", mdi.MDOut, 32'hFFFF_FFFF);
        mdi.MDOp = MD_MFLO;
        #1;
        check("mflo_mdout", mdi.MDOut, 32'hFFFF_FFEB);
        mdi.MDOp = MD_NONE;
        #1;
        check("none_mdout2", mdi.MDOut, 32'd0);

        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("divu", MD_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);
        run_op("div_neg_a", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_neg_b", MD_DIV, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);
        run_op("div_zero", MD_DIV, 32'h8000_0000, 32'd0, 10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_zero", MD_DIVU, 32'd55, 32'd0, 10, 32'd55, 32'hFFFF_FFFF);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

        launch(MD_MTHI, 32'h0000_1234, 32'd0);
        check("mthi_hi", mdi.HI, 32'h0000_1234);
        check("mthi_busy", {31'd0, mdi.busy}, 32'd0);
        check("mthi_lo_kept", mdi.LO, 32'h8000_0000);

        launch(MD_MULTU, 32'd2, 32'd3);
        check("multu_busy_on", {31'd0, mdi.busy}, 32'd1);
        mdi.MDOp  = MD_MTLO;
        mdi.A     = 32'hDEAD_BEEF;
        mdi.start = 1'b1;
        step();
        mdi.start = 1'b0;
        mdi.MDOp  = MD_NONE;
        check("mtlo_busy_ignored", mdi.LO, 32'h8000_0000);
        wait_idle(nb);
        check("multu_rest_cycles", nb, 4);
        check("multu_hi", mdi.HI, 32'd0);
        check("multu_lo", mdi.LO, 32'd6);

        launch(MD_DIV, 32'd100, 32'd7);
        step();
        step();
        step();
        check("abort_busy_c4", {31'd0, mdi.busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", {31'd0, mdi.busy}, 32'd0);
        check("abort_hi", mdi.HI, 32'd0);
        check("abort_lo", mdi.LO, 32'd0);
        repeat (12) step();
        check("abort_late_hi", mdi.HI, 32'd0);
        check("abort_late_lo", mdi.LO, 32'd0);

        launch(MD_MTLO, 32'hFFFF_FFFF, 32'd0);
        check("mtlo_lo", mdi.LO, 32'hFFFF_FFFF);
`ifdef MD_MADD_EN
        run_op("maddu", MD_MADDU, 32'd1, 32'd1, 5, 32'd1, 32'd0);
`else
        launch(MD_MADDU, 32'd1, 32'd1);
        check("maddu_off_busy", {31'd0, mdi.busy}, 32'd0);
        repeat (6) step();
        check("maddu_off_hi", mdi.HI, 32'd0);
        check("maddu_off_lo", mdi.LO, 32'hFFFF_FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
